// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage of the five-stage pipeline. This stage sits
//            directly after the EX/MEM register and does the following:
//            - issues load/store transactions over a req/ack handshake;
//            - stalls the upstream pipeline while a transaction is pending;
//            - produces the MEM/WB pipeline register;
//            - resolves the branch-taken select.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   TIMEOUT             max REQ cycles waiting for dmem_ack (2..255)
// Build option:
//   MEM_ALIGN_CHECK_EN  when defined, an access whose address[1:0] != 0 is
//                       not issued. It is retired as a non-writing
//                       instruction and sets the sticky bus_err flag.
// Ports:
//   clk, rst                        clock, async active-high reset
//   *_ex_mem                        EX/MEM register contents (inputs)
//   dmem_req/we/addr/wdata          registered data-memory request (outputs)
//   dmem_ack, dmem_rdata            data-memory response (inputs)
//   stall_mem                       comb. freeze of PC, IF/ID, ID/EX, EX/MEM
//   pcsrc_mem                       comb. branch taken (branch & zero)
//   *_mem_wb                        MEM/WB register contents (outputs)
//   bus_err                         sticky timeout/alignment error flag
// ============================================================================
module mem_stage #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_ex_mem,
  input  logic        mem_write_ex_mem,
  input  logic        mem_to_reg_ex_mem,
  input  logic        reg_write_ex_mem,
  input  logic        branch_ex_mem,
  input  logic        zero_ex_mem,
  input  logic [4:0]  writebackreg_ex_mem,
  input  logic [31:0] alu_result_ex_mem,
  input  logic [31:0] rt_data_ex_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        pcsrc_mem,
  output logic        reg_write_mem_wb,
  output logic        mem_to_reg_mem_wb,
  output logic [4:0]  writebackreg_mem_wb,
  output logic [31:0] alu_result_mem_wb,
  output logic [31:0] mem_data_mem_wb,
  output logic        bus_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic       access;
  logic       misaligned;
  logic       tmo_hit;

  // A simultaneous read and write is treated as a store; dmem_we is taken
  // straight from mem_write_ex_mem, which gives that priority.
  assign access  = mem_read_ex_mem | mem_write_ex_mem;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (alu_result_ex_mem[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Branch select is independent of any memory stall.
  assign pcsrc_mem = branch_ex_mem & zero_ex_mem;

  // The stall drops in the completing (ack) or aborting cycle. This lets
  // EX/MEM advance on the same edge that MEM/WB captures the result.
  always_comb begin
    stall_mem = 1'b0;
    case (state)
      IDLE:    stall_mem = access & ~misaligned;
      REQ:     stall_mem = ~dmem_ack & ~tmo_hit;
      default: stall_mem = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      tmo_cnt             <= 8'd0;
      dmem_req            <= 1'b0;
      dmem_we             <= 1'b0;
      dmem_addr           <= 32'd0;
      dmem_wdata          <= 32'd0;
      reg_write_mem_wb    <= 1'b0;
      mem_to_reg_mem_wb   <= 1'b0;
      writebackreg_mem_wb <= 5'd0;
      alu_result_mem_wb   <= 32'd0;
      mem_data_mem_wb     <= 32'd0;
      bus_err             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !misaligned) begin
            // Launch the transaction; MEM/WB takes a bubble while stalled.
            dmem_req          <= 1'b1;
            dmem_we           <= mem_write_ex_mem;
            dmem_addr         <= alu_result_ex_mem;
            dmem_wdata        <= rt_data_ex_mem;
            tmo_cnt           <= 8'd0;
            state             <= REQ;
            reg_write_mem_wb  <= 1'b0;
            mem_to_reg_mem_wb <= 1'b0;
          end else if (access) begin
            // Misaligned access: retire without writing a register.
            reg_write_mem_wb    <= 1'b0;
            mem_to_reg_mem_wb   <= mem_to_reg_ex_mem;
            writebackreg_mem_wb <= writebackreg_ex_mem;
            alu_result_mem_wb   <= alu_result_ex_mem;
            mem_data_mem_wb     <= 32'd0;
            bus_err             <= 1'b1;
          end else begin
            reg_write_mem_wb    <= reg_write_ex_mem;
            mem_to_reg_mem_wb   <= mem_to_reg_ex_mem;
            writebackreg_mem_wb <= writebackreg_ex_mem;
            alu_result_mem_wb   <= alu_result_ex_mem;
            mem_data_mem_wb     <= 32'd0;
          end
        end

        REQ: begin
          if (dmem_ack) begin
            // EX/MEM was frozen, so it still holds the requesting instruction.
            dmem_req            <= 1'b0;
            state               <= IDLE;
            reg_write_mem_wb    <= reg_write_ex_mem;
            mem_to_reg_mem_wb   <= mem_to_reg_ex_mem;
            writebackreg_mem_wb <= writebackreg_ex_mem;
            alu_result_mem_wb   <= alu_result_ex_mem;
            mem_data_mem_wb     <= dmem_we ? 32'd0 : dmem_rdata;
          end else if (tmo_hit) begin
            dmem_req            <= 1'b0;
            state               <= IDLE;
            bus_err             <= 1'b1;
            reg_write_mem_wb    <= 1'b0;
            mem_to_reg_mem_wb   <= mem_to_reg_ex_mem;
            writebackreg_mem_wb <= writebackreg_ex_mem;
            alu_result_mem_wb   <= alu_result_ex_mem;
            mem_data_mem_wb     <= 32'd0;
          end else begin
            tmo_cnt           <= tmo_cnt + 8'd1;
            reg_write_mem_wb  <= 1'b0;
            mem_to_reg_mem_wb <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage. It covers:
//            - reset in the middle of a request;
//            - an ALU op;
//            - a wait-state load and a zero-wait store;
//            - a timeout abort;
//            - branch select;
//            - the alignment build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_ex_mem, mem_write_ex_mem, mem_to_reg_ex_mem, reg_write_ex_mem;
  logic        branch_ex_mem, zero_ex_mem;
  logic [4:0]  writebackreg_ex_mem;
  logic [31:0] alu_result_ex_mem, rt_data_ex_mem;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_mem, pcsrc_mem;
  logic        reg_write_mem_wb, mem_to_reg_mem_wb;
  logic [4:0]  writebackreg_mem_wb;
  logic [31:0] alu_result_mem_wb, mem_data_mem_wb;
  logic        bus_err;

  int errors = 0;
  int checks = 0;
  int nstall;
  int nreq;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_read_ex_mem     (mem_read_ex_mem),
    .mem_write_ex_mem    (mem_write_ex_mem),
    .mem_to_reg_ex_mem   (mem_to_reg_ex_mem),
    .reg_write_ex_mem    (reg_write_ex_mem),
    .branch_ex_mem       (branch_ex_mem),
    .zero_ex_mem         (zero_ex_mem),
    .writebackreg_ex_mem (writebackreg_ex_mem),
    .alu_result_ex_mem   (alu_result_ex_mem),
    .rt_data_ex_mem      (rt_data_ex_mem),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_ack            (dmem_ack),
    .dmem_rdata          (dmem_rdata),
    .stall_mem           (stall_mem),
    .pcsrc_mem           (pcsrc_mem),
    .reg_write_mem_wb    (reg_write_mem_wb),
    .mem_to_reg_mem_wb   (mem_to_reg_mem_wb),
    .writebackreg_mem_wb (writebackreg_mem_wb),
    .alu_result_mem_wb   (alu_result_mem_wb),
    .mem_data_mem_wb     (mem_data_mem_wb),
    .bus_err             (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex;
    mem_read_ex_mem     = 1'b0;
    mem_write_ex_mem    = 1'b0;
    mem_to_reg_ex_mem   = 1'b0;
    reg_write_ex_mem    = 1'b0;
    branch_ex_mem       = 1'b0;
    zero_ex_mem         = 1'b0;
    writebackreg_ex_mem = 5'd0;
    alu_result_ex_mem   = 32'd0;
    rt_data_ex_mem      = 32'd0;
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    clear_ex();
    tick();
    tick();
    @(negedge clk);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_regwr", {31'd0, reg_write_mem_wb}, 32'd0);
    check("rst_alu", alu_result_mem_wb, 32'd0);
    check("rst_buserr", {31'd0, bus_err}, 32'd0);
    tick();
    rst = 1'b0;

    // ALU op: one-cycle latency, never stalls.
    reg_write_ex_mem    = 1'b1;
    writebackreg_ex_mem = 5'd5;
    alu_result_ex_mem   = 32'h1234;
    @(negedge clk);
    check("alu_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    check("alu_res", alu_result_mem_wb, 32'h1234);
    check("alu_reg", {27'd0, writebackreg_mem_wb}, 32'd5);
    check("alu_regwr", {31'd0, reg_write_mem_wb}, 32'd1);

    // Load to 0x40 interrupted by reset while in REQ.
    mem_read_ex_mem     = 1'b1;
    mem_to_reg_ex_mem   = 1'b1;
    writebackreg_ex_mem = 5'd7;
    alu_result_ex_mem   = 32'h40;
    @(negedge clk);
    check("ld40_stall", {31'd0, stall_mem}, 32'd1);
    tick();
    check("ld40_req", {31'd0, dmem_req}, 32'd1);
    check("ld40_addr", dmem_addr, 32'h40);
    check("ld40_bubble", {31'd0, reg_write_mem_wb}, 32'd0);
    check("ld40_hold", alu_result_mem_wb, 32'h1234);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_req", {31'd0, dmem_req}, 32'd0);
    check("arst_alu", alu_result_mem_wb, 32'd0);
    check("arst_wbreg", {27'd0, writebackreg_mem_wb}, 32'd0);
    check("arst_md", mem_data_mem_wb, 32'd0);
    clear_ex();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    check("arst_idle_req", {31'd0, dmem_req}, 32'd0);

    // Load 0x100, ack in the 4th REQ cycle.
    mem_read_ex_mem     = 1'b1;
    mem_to_reg_ex_mem   = 1'b1;
    reg_write_ex_mem    = 1'b1;
    writebackreg_ex_mem = 5'd9;
    alu_result_ex_mem   = 32'h100;
    nstall = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
      end
      @(negedge clk);
      if (stall_mem) nstall++;
      if (i > 0) check("ld_addr", dmem_addr, 32'h100);
      tick();
    end
    dmem_ack = 1'b0;
    clear_ex();
    check("ld_nstall", nstall, 32'd4);
    check("ld_data", mem_data_mem_wb, 32'hCAFEF00D);
    check("ld_regwr", {31'd0, reg_write_mem_wb}, 32'd1);
    check("ld_m2r", {31'd0, mem_to_reg_mem_wb}, 32'd1);
    check("ld_wbreg", {27'd0, writebackreg_mem_wb}, 32'd9);
    check("ld_req_done", {31'd0, dmem_req}, 32'd0);

    // Store 0x20, zero-wait ack.
    tick();
    mem_write_ex_mem  = 1'b1;
    alu_result_ex_mem = 32'h20;
    rt_data_ex_mem    = 32'hA5A5A5A5;
    @(negedge clk);
    check("st_stall0", {31'd0, stall_mem}, 32'd1);
    tick();
    check("st_req", {31'd0, dmem_req}, 32'd1);
    check("st_we", {31'd0, dmem_we}, 32'd1);
    check("st_addr", dmem_addr, 32'h20);
    check("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("st_stall1", {31'd0, stall_mem}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    clear_ex();
    check("st_mdata", mem_data_mem_wb, 32'd0);
    check("st_buserr", {31'd0, bus_err}, 32'd0);
    check("st_req_done", {31'd0, dmem_req}, 32'd0);

    // Misaligned load at 0x102.
    tick();
    mem_read_ex_mem     = 1'b1;
    mem_to_reg_ex_mem   = 1'b1;
    reg_write_ex_mem    = 1'b1;
    writebackreg_ex_mem = 5'd3;
    alu_result_ex_mem   = 32'h102;
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    check("mis_stall", {31'd0, stall_mem}, 32'd0);
    tick();
    clear_ex();
    check("mis_req", {31'd0, dmem_req}, 32'd0);
    check("mis_regwr", {31'd0, reg_write_mem_wb}, 32'd0);
    check("mis_buserr", {31'd0, bus_err}, 32'd1);
    check("mis_alu", alu_result_mem_wb, 32'h102);
`else
    @(negedge clk);
    check("mis_stall", {31'd0, stall_mem}, 32'd1);
    tick();
    check("mis_req", {31'd0, dmem_req}, 32'd1);
    check("mis_addr", dmem_addr, 32'h102);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h11112222;
    tick();
    dmem_ack = 1'b0;
    clear_ex();
    check("mis_data", mem_data_mem_wb, 32'h11112222);
    check("mis_regwr", {31'd0, reg_write_mem_wb}, 32'd1);
    check("mis_buserr", {31'd0, bus_err}, 32'd0);
`endif

    // Branch select is combinational.
    tick();
    branch_ex_mem = 1'b1;
    zero_ex_mem   = 1'b1;
    #1;
    check("pcsrc_taken", {31'd0, pcsrc_mem}, 32'd1);
    zero_ex_mem = 1'b0;
    #1;
    check("pcsrc_not", {31'd0, pcsrc_mem}, 32'd0);
    clear_ex();

    // Load 0x200 with no ack: abort after 4 REQ cycles (TIMEOUT = 4).
    tick();
    mem_read_ex_mem     = 1'b1;
    mem_to_reg_ex_mem   = 1'b1;
    reg_write_ex_mem    = 1'b1;
    writebackreg_ex_mem = 5'd11;
    alu_result_ex_mem   = 32'h200;
    nstall = 0;
    nreq   = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stall_mem) nstall++;
      if (dmem_req) nreq++;
      if (i == 4) check("to_abort_stall", {31'd0, stall_mem}, 32'd0);
      tick();
    end
    clear_ex();
    check("to_nreq", nreq, 32'd4);
    check("to_nstall", nstall, 32'd4);
    check("to_buserr", {31'd0, bus_err}, 32'd1);
    check("to_regwr", {31'd0, reg_write_mem_wb}, 32'd0);
    check("to_req", {31'd0, dmem_req}, 32'd0);
    check("to_mdata", mem_data_mem_wb, 32'd0);
    tick();
    tick();
    tick();
    check("to_sticky", {31'd0, bus_err}, 32'd1);
    check("to_idle_req", {31'd0, dmem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
